// File: rtl/wb_bridge_pkg.sv
// Shared types and lane constants for the 8->32 Wishbone upsize bridge.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  localparam int BYTE_LANES = 4;
  localparam int LANE_BITS  = 2;

endpackage

// File: rtl/wb_if.sv
// Wishbone classic bus bundle with master/slave views.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 8
);
  localparam int SW = (DW / 8 < 1) ? 1 : DW / 8;

  logic [AW-1:0] ADR;
  logic [DW-1:0] DAT_W;
  logic [DW-1:0] DAT_R;
  logic          CYC;
  logic          STB;
  logic          WE;
  logic [SW-1:0] SEL;
  logic          ACK;
  logic          ERR;

  modport master (
    output ADR, DAT_W, CYC, STB, WE, SEL,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, DAT_W, CYC, STB, WE, SEL,
    output DAT_R, ACK, ERR
  );

endinterface

// File: rtl/wb_bridge_timeout.sv
// Target wait-cycle watchdog; a zero limit never expires.
module wb_bridge_timeout #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_d = cnt_q + W'(1);

  // Fires on the limit-th unanswered cycle so the error lands on that edge.
  assign expired = enable
                && (limit != '0)
                && (cnt_q == limit - W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_upsize_bridge.sv
// Bridges an 8-bit Wishbone initiator onto a 32-bit target,
// one byte-lane transfer per initiator request.
module wb_upsize_bridge
  import wb_bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int IN_DATA_WIDTH  = 8,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic  clk,
  input logic  rstn,
  wb_if.slave  in,
  wb_if.master out
);

  if (IN_DATA_WIDTH == 8 && OUT_DATA_WIDTH == 32) begin : g_bridge

    localparam int AW = ADDRESS_WIDTH;
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1
                      : $clog2(TIMEOUT_CYCLES + 1);

    state_e                 state_q;
    logic [AW-1:0]          out_adr_q;
    logic [3:0]             out_sel_q;
    logic [31:0]            out_dat_w_q;
    logic                   out_we_q;
    logic                   out_cyc_q;
    logic [LANE_BITS-1:0]   lane_q;
    logic                   in_ack_q;
    logic                   in_err_q;
    logic [7:0]             in_dat_r_q;

    logic req_v;
    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;
    logic out_fail;

    assign req_v      = in.CYC && in.STB;
    assign tmo_clear  = (state_q != REQ);
    assign tmo_enable = (state_q == REQ) && in.CYC
                     && !out.ACK && !out.ERR;
    assign out_fail   = out.ERR || tmo_expired;

    wb_bridge_timeout #(
      .W(TW)
    ) u_timeout (
      .clk    (clk),
      .rstn   (rstn),
      .clear  (tmo_clear),
      .enable (tmo_enable),
      .limit  (TW'(TIMEOUT_CYCLES)),
      .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q     <= IDLE;
        out_adr_q   <= '0;
        out_sel_q   <= '0;
        out_dat_w_q <= '0;
        out_we_q    <= 1'b0;
        out_cyc_q   <= 1'b0;
        lane_q      <= '0;
        in_ack_q    <= 1'b0;
        in_err_q    <= 1'b0;
        in_dat_r_q  <= '0;
      end else begin
        in_ack_q <= 1'b0;
        in_err_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (req_v && in.SEL[0]) begin
              out_adr_q   <= {in.ADR[AW-1:LANE_BITS],
                              LANE_BITS'(0)};
              out_sel_q   <= 4'b0001 << in.ADR[LANE_BITS-1:0];
              out_dat_w_q <= {BYTE_LANES{in.DAT_W}};
              out_we_q    <= in.WE;
              lane_q      <= in.ADR[LANE_BITS-1:0];
              out_cyc_q   <= 1'b1;
              state_q     <= REQ;
            end else if (req_v) begin
              in_dat_r_q <= '0;
              in_ack_q   <= 1'b1;
              state_q    <= RESP;
            end
          end
          REQ: begin
            if (!in.CYC) begin
              out_cyc_q <= 1'b0;
              state_q   <= IDLE;
            end else if (out_fail) begin
              out_cyc_q <= 1'b0;
              in_err_q  <= 1'b1;
              state_q   <= RESP;
            end else if (out.ACK) begin
              out_cyc_q <= 1'b0;
              in_ack_q  <= 1'b1;
              state_q   <= RESP;
              if (!out_we_q) begin
                in_dat_r_q <= out.DAT_R[{lane_q, 3'b000} +: 8];
              end
            end
          end
          RESP: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end

    assign out.ADR   = out_adr_q;
    assign out.SEL   = out_sel_q;
    assign out.DAT_W = out_dat_w_q;
    assign out.WE    = out_we_q;
    assign out.CYC   = out_cyc_q;
    assign out.STB   = out_cyc_q;
    assign in.ACK    = in_ack_q;
    assign in.ERR    = in_err_q;
    assign in.DAT_R  = in_dat_r_q;

  end else begin : g_unsupported

    $warning("Error %m: Unsupported width pair %0d->%0d",
             IN_DATA_WIDTH, OUT_DATA_WIDTH);

    assign out.ADR   = '0;
    assign out.SEL   = '0;
    assign out.DAT_W = '0;
    assign out.WE    = 1'b0;
    assign out.CYC   = 1'b0;
    assign out.STB   = 1'b0;
    assign in.ACK    = 1'b0;
    assign in.ERR    = 1'b0;
    assign in.DAT_R  = '0;

  end

endmodule

// File: tb/tb_wb_upsize_bridge.sv
// Vector table plus response scoreboard for the upsize bridge.
module tb_wb_upsize_bridge;

  typedef struct {
    logic [31:0] adr;
    logic [7:0]  dat_w;
    bit          we;
    bit          sel;
    int          waits;
    logic [31:0] tdat;
    int          mode;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_datw;
    bit          exp_err;
    logic [7:0]  exp_datr;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit         err;
    logic [7:0] dat;
    int         req_cyc;
    int         lat;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  wb_if #(.AW(32), .DW(8))  in_bus ();
  wb_if #(.AW(32), .DW(32)) out_bus ();

  wb_upsize_bridge #(
    .ADDRESS_WIDTH (32),
    .IN_DATA_WIDTH (8),
    .OUT_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .in  (in_bus),
    .out (out_bus)
  );

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc_cnt    = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   prev_resp  = 1'b0;
  vec_t vt[10];
  vec_t rd0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic void chk(string name,
                              logic [63:0] act,
                              logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Scoreboard: every initiator response must match the oldest entry.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_resp = 1'b0;
    end else begin
      if (in_bus.ACK || in_bus.ERR) begin
        chk("resp_pulse_len", prev_resp, 0);
        chk("resp_ack_and_err", in_bus.ACK & in_bus.ERR, 0);
        chk("resp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("resp_err", in_bus.ERR, mon_e.err);
          chk("resp_datr", in_bus.DAT_R, mon_e.dat);
          chk("resp_latency", cyc_cnt - mon_e.req_cyc + 1,
              mon_e.lat);
        end
      end
      prev_resp = in_bus.ACK || in_bus.ERR;
    end
  end

  task automatic xfer(input vec_t v);
    bit got;
    @(posedge clk); #1;
    in_bus.ADR   = v.adr;
    in_bus.DAT_W = v.dat_w;
    in_bus.WE    = v.we;
    in_bus.SEL   = v.sel;
    in_bus.CYC   = 1'b1;
    in_bus.STB   = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{v.exp_err, v.exp_datr, cyc_cnt, v.exp_lat});
    if (v.sel) begin
      for (int k = 0; k <= v.waits; k++) begin
        out_bus.DAT_R = v.tdat;
        if (k == v.waits && v.mode != 3) begin
          out_bus.ACK = (v.mode == 0 || v.mode == 2);
          out_bus.ERR = (v.mode == 1 || v.mode == 2);
        end
        @(negedge clk);
        chk("out_adr", out_bus.ADR, v.exp_adr);
        chk("out_sel", out_bus.SEL, v.exp_sel);
        chk("out_datw", out_bus.DAT_W, v.exp_datw);
        chk("out_we", out_bus.WE, v.we);
        chk("out_cyc_stb", {out_bus.CYC, out_bus.STB}, 2'b11);
        @(posedge clk); #1;
        out_bus.ACK = 1'b0;
        out_bus.ERR = 1'b0;
      end
    end
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = in_bus.ACK || in_bus.ERR;
    end
    chk("resp_seen", got, 1);
    chk("out_cyc_in_resp", {out_bus.CYC, out_bus.STB}, 0);
    @(posedge clk); #1;
    in_bus.CYC = 1'b0;
    in_bus.STB = 1'b0;
    in_bus.SEL = 1'b0;
    in_bus.WE  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_bus.ADR    = '0;
    in_bus.DAT_W  = '0;
    in_bus.WE     = 1'b0;
    in_bus.SEL    = 1'b0;
    in_bus.CYC    = 1'b0;
    in_bus.STB    = 1'b0;
    out_bus.DAT_R = '0;
    out_bus.ACK   = 1'b0;
    out_bus.ERR   = 1'b0;

    vt[0] = '{32'h1003, 8'hA5, 1, 1, 0, 32'h0, 0,
              32'h1000, 4'b1000, 32'hA5A5A5A5, 0, 8'h00, 2};
    vt[1] = '{32'h2001, 8'h00, 0, 1, 3, 32'h11223344, 0,
              32'h2000, 4'b0010, 32'h0, 0, 8'h33, 5};
    vt[2] = '{32'h0032, 8'h00, 0, 1, 1, 32'hDEADBEEF, 0,
              32'h0030, 4'b0100, 32'h0, 0, 8'hAD, 3};
    vt[3] = '{32'h4000, 8'h5A, 1, 1, 2, 32'h0, 1,
              32'h4000, 4'b0001, 32'h5A5A5A5A, 1, 8'hAD, 4};
    vt[4] = '{32'h5003, 8'h00, 0, 1, 0, 32'hFFFFFFFF, 2,
              32'h5000, 4'b1000, 32'h0, 1, 8'hAD, 2};
    vt[5] = '{32'h6000, 8'h00, 0, 1, 15, 32'h0, 3,
              32'h6000, 4'b0001, 32'h0, 1, 8'hAD, 17};
    vt[6] = '{32'h7003, 8'h00, 0, 1, 0, 32'h99887766, 0,
              32'h7000, 4'b1000, 32'h0, 0, 8'h99, 2};
    vt[7] = '{32'h8000, 8'h00, 0, 0, 0, 32'h0, 0,
              32'h0, 4'b0, 32'h0, 0, 8'h00, 1};
    vt[8] = '{32'h9002, 8'hC3, 1, 1, 1, 32'h0, 0,
              32'h9000, 4'b0100, 32'hC3C3C3C3, 0, 8'h00, 3};
    vt[9] = '{32'hC001, 8'h00, 0, 1, 0, 32'h0000AB00, 0,
              32'hC000, 4'b0010, 32'h0, 0, 8'hAB, 2};
    rd0   = '{32'h0000, 8'h00, 0, 1, 0, 32'h11223344, 0,
              32'h0000, 4'b0001, 32'h0, 0, 8'h44, 2};

    #1 rstn = 1'b0;
    #2;
    chk("reset_out_adr_datw", {out_bus.ADR, out_bus.DAT_W}, 0);
    chk("reset_ctrl", {out_bus.CYC, out_bus.STB, out_bus.WE,
        out_bus.SEL, in_bus.ACK, in_bus.ERR, in_bus.DAT_R}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 10; i++) xfer(vt[i]);

    // Initiator abandons the cycle two cycles into the target wait.
    @(posedge clk); #1;
    in_bus.ADR = 32'hA001;
    in_bus.WE  = 1'b0;
    in_bus.SEL = 1'b1;
    in_bus.CYC = 1'b1;
    in_bus.STB = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pre_cyc", out_bus.CYC, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_bus.CYC = 1'b0;
    in_bus.STB = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cyc_drop", {out_bus.CYC, out_bus.STB}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_resp", {in_bus.ACK, in_bus.ERR}, 0);
      @(negedge clk);
    end
    chk("abort_hold_datr", in_bus.DAT_R, 8'hAB);

    // Reset while the target is still holding off a write.
    @(posedge clk); #1;
    in_bus.ADR   = 32'hB002;
    in_bus.DAT_W = 8'h77;
    in_bus.WE    = 1'b1;
    in_bus.SEL   = 1'b1;
    in_bus.CYC   = 1'b1;
    in_bus.STB   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_cyc", out_bus.CYC, 1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_adr_datw", {out_bus.ADR, out_bus.DAT_W}, 0);
    chk("rst_mid_ctrl", {out_bus.CYC, out_bus.STB, out_bus.WE,
        out_bus.SEL, in_bus.ACK, in_bus.ERR, in_bus.DAT_R}, 0);
    in_bus.CYC = 1'b0;
    in_bus.STB = 1'b0;
    in_bus.WE  = 1'b0;
    in_bus.SEL = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_resp", {in_bus.ACK, in_bus.ERR,
          out_bus.CYC}, 0);
    end

    xfer(rd0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_upsize_bridge.md
WB_UPSIZE_BRIDGE -- requirements
Module: wb_upsize_bridge

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: address width of both ports.
REQ-002 Parameter IN_DATA_WIDTH, default 8: data width of the slave port (initiator side).
REQ-003 Parameter OUT_DATA_WIDTH, default 32: data width of the master port (target side).
REQ-004 Parameter TIMEOUT_CYCLES, default 256: max target wait cycles before error; 0 disables the timeout.
REQ-005 clk  input  1  single clock; all state SHALL be clocked on the rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 in  wb_if.slave  IN_DATA_WIDTH data  8-bit initiator port; uses ADR, DAT_W, DAT_R, CYC, STB, WE, SEL[0], ACK, ERR.
REQ-008 out  wb_if.master  OUT_DATA_WIDTH data  32-bit target port; uses ADR, DAT_W, DAT_R, CYC, STB, WE, SEL[3:0], ACK, ERR.
REQ-009 Any width pair other than 8->32 SHALL print "Error %m: Unsupported ..." at elaboration and drive all outputs 0.

Function
REQ-010 FSM states IDLE, REQ, RESP; reset state IDLE.
REQ-011 IDLE: on in.CYC&&in.STB&&in.SEL[0], capture ADR, DAT_W, WE and go to REQ.
REQ-012 IDLE with in.CYC&&in.STB&&!in.SEL[0] (null access): go to RESP with ACK pending, in.DAT_R=0, no outbound cycle.
REQ-013 REQ outputs, all registered: out.ADR={adr[AW-1:2],2'b00}; out.SEL=4'b0001<<adr[1:0]; out.DAT_W={4{dat_w}}; out.WE=captured WE; out.CYC=out.STB=1.
REQ-014 REQ: out.* SHALL remain stable until out.ACK, out.ERR, timeout or abort.
REQ-015 REQ on out.ACK: latch out.DAT_R[8*adr[1:0]+:8] into in.DAT_R (reads; writes leave it unchanged), deassert out.CYC/STB next edge, go RESP with ACK pending.
REQ-016 REQ on out.ERR: go RESP with ERR pending; out.ERR wins if asserted together with out.ACK.
REQ-017 Timeout counter: cleared on REQ entry, increments each REQ cycle without out.ACK/out.ERR; on reaching TIMEOUT_CYCLES, treated as out.ERR.
REQ-018 Abort: in.CYC low during REQ -> drop out.CYC/STB next edge, return IDLE, no in.ACK/in.ERR.
REQ-019 RESP: assert exactly one of in.ACK/in.ERR for exactly one cycle, then IDLE; never both.
REQ-020 in.ACK/in.ERR SHALL be asserted only in RESP; out.CYC/STB only in REQ.
REQ-021 Latency: request sampled at edge N -> out.STB from N+1; target ACK at edge N+1+W -> in.ACK high in cycle after, i.e. min 2 cycles, 2+W total.
REQ-022 in.DAT_R SHALL hold its value between transfers.

Reset
REQ-023 rstn low SHALL asynchronously force: state IDLE, counter 0, out.CYC/STB/WE=0, out.SEL=0, out.ADR=0, out.DAT_W=0, in.ACK=0, in.ERR=0, in.DAT_R=0.
REQ-024 Reset mid-transfer SHALL abandon it with no response; first request after rstn rises is accepted normally.

Structure
REQ-025 Package wb_bridge_pkg SHALL hold the state enum (IDLE/REQ/RESP) and lane constants (BYTE_LANES=4, LANE_BITS=2).
REQ-026 Timeout counter SHALL be a sub-module wb_bridge_timeout (clk, rstn, clear, enable, limit, expired).

Verification
REQ-027 Write: in ADR=0x1003, DAT_W=0xA5, SEL=1, target ACK 0 waits -> out.ADR=0x1000, SEL=4'b1000, DAT_W=0xA5A5A5A5; in.ACK 2 cycles after request.
REQ-028 Read: ADR=0x2001, target DAT_R=0x11223344, ACK after 3 waits -> in.DAT_R=0x33, in.ACK 5 cycles after request, single cycle.
REQ-029 Target never ACKs, TIMEOUT_CYCLES=16 -> out.CYC drops and in.ERR pulses once after 16 REQ cycles; next request completes normally.
REQ-030 Target asserts ACK and ERR together -> in.ERR=1, in.ACK=0, in.DAT_R unchanged.
REQ-031 in.CYC dropped 2 cycles into REQ -> out.CYC low next cycle, no in.ACK/in.ERR; SEL=0 request -> in.ACK, no out.CYC.
REQ-032 rstn pulsed low mid-REQ -> all outputs 0 immediately, no response; read of ADR=0x0 after reset returns lane 0 correctly.
